uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that consumes the byte stream produced by the CPU system's memory-mapped output port (`out_byte`/`out_byte_en`, store to 0x2000_0000). Single-cycle byte strobes are queued in a small FIFO and serialized LSB-first on `tx` at a fixed baud divisor. The block sits directly downstream of the system and drives the board UART pin. An optional even-parity bit is configurable.

---
 rtl/uart_tx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1 by default.
// Define UART_TX_PARITY_EN to compile in an even-parity bit (8E1 frame).
module uart_tx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  input  logic       clear_ovf,
  output logic       tx,
  output logic       fifo_full,
  output logic       busy,
  output logic       overflow
);
  // state  | meaning
  // IDLE   | line idle (tx=1), waiting for FIFO data
  // START  | start bit (tx=0)
  // DATA   | 8 data bits, LSB first
  // PARITY | even parity bit (parity build only)
  // STOP   | stop bit (tx=1); chains straight into START if data waits
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          fifo_ne, bit_last, push, pop;
`ifdef UART_TX_PARITY_EN
  logic          par_bit;
`endif

  assign fifo_ne   = (count != '0);
  assign fifo_full = (count == FULL_CNT);
  assign busy      = (state != IDLE) || fifo_ne;
  assign bit_last  = (bit_cnt == CNT_LAST);
  // Acceptance uses the pre-edge full flag, so a same-cycle pop never frees room.
  assign push = in_valid && !fifo_full;
  assign pop  = fifo_ne && ((state == IDLE) || (state == STOP && bit_last));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_byte;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && fifo_full) overflow <= 1'b1;
      else if (clear_ovf)        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      if (pop) begin
        shreg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
        par_bit <= ^mem[rd_ptr];
`endif
      end
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (fifo_ne) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_last) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (fifo_ne) begin
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a queue-level model predicts accepted
// bytes and frame start cycles; a serial monitor decodes tx and compares.
module tb_uart_tx_fifo;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CLK_DIV;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       tx, fifo_full, busy, overflow;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .resetn(resetn), .in_byte(in_byte), .in_valid(in_valid),
    .clear_ovf(clear_ovf), .tx(tx), .fifo_full(fifo_full), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: FIFO contents as a queue, line occupancy as a cycle count.
  logic [7:0] mq[$];
  int         frame_left = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] exp_byte[$];
  int         exp_cyc[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      exp_byte.delete();
      exp_cyc.delete();
      frame_left = 0;
      m_ovf = 1'b0;
    end else begin
      bit full_pre;
      cyc++;
      full_pre = (mq.size() == FIFO_DEPTH);
      if (frame_left > 0) frame_left--;
      if (frame_left == 0 && mq.size() > 0) begin
        exp_byte.push_back(mq.pop_front());
        exp_cyc.push_back(cyc);
        frame_left = FL;
      end
      if (in_valid && !full_pre) mq.push_back(in_byte);
      if (in_valid && full_pre) m_ovf = 1'b1;
      else if (clear_ovf)       m_ovf = 1'b0;
    end
  end

  // Serial monitor.
  bit         in_frame = 1'b0;
  int         pos = 0;
  int         start_cyc = 0;
  bit         glitch = 1'b0;
  logic       bits [NB];

  task automatic finish_frame();
    logic [7:0] got, eb;
    int ec;
    for (int i = 0; i < 8; i++) got[i] = bits[i+1];
    if (exp_byte.size() == 0) begin
      chk("unexpected_frame", {24'h0, got}, 32'hFFFF_FFFF);
    end else begin
      eb = exp_byte.pop_front();
      ec = exp_cyc.pop_front();
      chk("frame_byte", {24'h0, got}, {24'h0, eb});
      chk("frame_start_cycle", start_cyc, ec);
      chk("stop_bit", {31'h0, bits[NB-1]}, 32'h1);
`ifdef UART_TX_PARITY_EN
      chk("parity_bit", {31'h0, bits[9]}, {31'h0, ^eb});
`endif
      chk("bit_stable", {31'h0, glitch}, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx == 1'b0) begin
        in_frame  = 1'b1;
        pos       = 0;
        bits[0]   = 1'b0;
        glitch    = 1'b0;
        start_cyc = cyc;
      end
    end else begin
      pos++;
      if (pos % CLK_DIV == 0) bits[pos/CLK_DIV] = tx;
      else if (tx !== bits[pos/CLK_DIV]) glitch = 1'b1;
      if (pos == FL - 1) begin
        in_frame = 1'b0;
        finish_frame();
      end
    end
    chk("fifo_full", {31'h0, fifo_full}, {31'h0, (mq.size() == FIFO_DEPTH)});
    chk("busy", {31'h0, busy}, {31'h0, (frame_left > 0 || mq.size() > 0)});
    chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
  end

  task automatic drive(input logic v, input logic [7:0] b, input logic c);
    @(negedge clk);
    in_valid  = v;
    in_byte   = b;
    clear_ovf = c;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (frame_left == 0 && mq.size() == 0 && !in_frame) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_idle: model still busy after 4000 cycles (cycle %0d)", cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'h0, tx}, 32'h1);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_full", {31'h0, fifo_full}, 32'h0);
    chk("reset_ovf", {31'h0, overflow}, 32'h0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single bytes, then a back-to-back pair.
    drive(1'b1, 8'h41, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    wait_idle();
    drive(1'b1, 8'h07, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    wait_idle();
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    wait_idle();

    // Six strobes into a depth-4 FIFO: byte5 dropped.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_after_drop", {31'h0, overflow}, 32'h1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);
    drive(1'b1, 8'hEE, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_set_wins", {31'h0, overflow}, 32'h1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    wait_idle();

    // Random traffic with occasional bursts and clears.
    for (int i = 0; i < 400; i++) begin
      logic v, c;
      v = ($urandom_range(0, 5) == 0) || (i % 97 < 6);
      c = ($urandom_range(0, 40) == 0);
      drive(v, 8'($urandom), c);
    end
    drive(1'b0, 8'h00, 1'b0);
    wait_idle();

    // Reset mid-frame with three bytes still queued.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_tx_async", {31'h0, tx}, 32'h1);
    chk("rst_busy_async", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (150) @(negedge clk);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_tx", {31'h0, tx}, 32'h1);
    chk("sb_drained", exp_byte.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
